// File: rtl/issue_scheduler_pkg.sv
// Shared issue-path constants, opcode map and slot payload type.
package issue_scheduler_pkg;

  localparam int unsigned ROB_SIZE_WIDTH = 3;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned OPC_W          = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // Instruction word and its PC as held in the issue slot.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
  } slot_t;

  // Loads and stores go to the LSB; everything else goes to the RS.
  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_router.sv
// Opcode-based destination select and back-pressure for the held instruction.
module issue_router
  import issue_scheduler_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             to_lsb_c,
  output logic             blocked_c
);

  // Destination is chosen by opcode; the RoB is needed by every instruction.
  always_comb begin
    to_lsb_c  = is_mem_op(opcode);
    blocked_c = rob_full | (to_lsb_c ? lsb_full : rs_full);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Single-entry issue slot between the Fetcher and the RoB/RS/LSB.
module issue_scheduler #(
  parameter int unsigned ROB_SIZE_WIDTH = issue_scheduler_pkg::ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      instr_valid,
  input  logic [31:0]               instr_in,
  input  logic [31:0]               instr_addr_in,
  output logic                      instr_ready,
  input  logic                      rob_full,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_tail,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  input  logic                      flush,
  output logic                      instr_issued,
  output logic                      to_lsb,
  output logic [31:0]               instr_out,
  output logic [31:0]               instr_addr_out,
  output logic [ROB_SIZE_WIDTH-1:0] rd_rob_id_out,
  output logic [31:0]               stall_cycles
);
  import issue_scheduler_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic             slot_valid;
  slot_t            slot;
  logic [CNT_W-1:0] stall_q;
  logic             to_lsb_c;
  logic             blocked_c;
  logic             accept_c;

  issue_router u_router (
    .opcode    (slot.instr[OPC_W-1:0]),
    .rob_full  (rob_full),
    .rs_full   (rs_full),
    .lsb_full  (lsb_full),
    .to_lsb_c  (to_lsb_c),
    .blocked_c (blocked_c)
  );

  // Handshake and issue decisions; flush and a frozen clock enable veto both.
  always_comb begin
    instr_issued   = rdy & slot_valid & ~blocked_c & ~flush;
    instr_ready    = rdy & ~flush & (~slot_valid | instr_issued);
    accept_c       = instr_valid & instr_ready;
    to_lsb         = to_lsb_c;
    instr_out      = slot.instr;
    instr_addr_out = slot.addr;
    rd_rob_id_out  = instr_issued ? rob_tail : {ROB_SIZE_WIDTH{1'b0}};
    stall_cycles   = stall_q;
  end

  // Slot register: flush empties, rdy low freezes, accept refills, issue drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= 1'b0;
      slot       <= '0;
    end else if (flush) begin
      slot_valid <= 1'b0;
    end else if (rdy) begin
      if (accept_c) begin
        slot_valid <= 1'b1;
        slot.instr <= instr_in;
        slot.addr  <= instr_addr_in;
      end else if (instr_issued) begin
        slot_valid <= 1'b0;
      end
    end
  end

  // Free-running count of cycles the held instruction spent back-pressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (rdy & slot_valid & blocked_c & ~flush) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: scoreboard on issue, table of routing vectors, directed corners.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int unsigned W = ROB_SIZE_WIDTH;

  localparam logic [31:0] I_ADDI1 = 32'h00100093;
  localparam logic [31:0] I_ADDI2 = 32'h00208113;
  localparam logic [31:0] I_LOAD  = 32'h0000A183;
  localparam logic [31:0] I_STORE = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_ADDI5 = 32'h00500293;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         instr_valid;
  logic [31:0]  instr_in;
  logic [31:0]  instr_addr_in;
  logic         instr_ready;
  logic         rob_full;
  logic [W-1:0] rob_tail;
  logic         rs_full;
  logic         lsb_full;
  logic         flush;
  logic         instr_issued;
  logic         to_lsb;
  logic [31:0]  instr_out;
  logic [31:0]  instr_addr_out;
  logic [W-1:0] rd_rob_id_out;
  logic [31:0]  stall_cycles;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic [31:0] instr;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        exp_issued;
    logic        exp_to_lsb;
  } vec_t;

  issue_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .instr_valid    (instr_valid),
    .instr_in       (instr_in),
    .instr_addr_in  (instr_addr_in),
    .instr_ready    (instr_ready),
    .rob_full       (rob_full),
    .rob_tail       (rob_tail),
    .rs_full        (rs_full),
    .lsb_full       (lsb_full),
    .flush          (flush),
    .instr_issued   (instr_issued),
    .to_lsb         (to_lsb),
    .instr_out      (instr_out),
    .instr_addr_out (instr_addr_out),
    .rd_rob_id_out  (rd_rob_id_out),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic model_to_lsb(input logic [31:0] ins);
    logic [6:0] opc;
    opc = ins[6:0];
    return (opc == 7'b0000011) || (opc == 7'b0100011);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; caller checks 2 time units later.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rf, input logic rsf, input logic lf,
                     input logic fl, input logic r, input logic [W-1:0] tail);
    @(negedge clk);
    instr_valid   = v;
    instr_in      = ins;
    instr_addr_in = pc;
    rob_full      = rf;
    rs_full       = rsf;
    lsb_full      = lf;
    flush         = fl;
    rdy           = r;
    rob_tail      = tail;
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  // Scoreboard: pop/compare on every issue, push on every accepted instruction.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      if (instr_issued) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_issue", 32'(instr_issued), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_instr", instr_out, e.instr);
          chk("sb_addr", instr_addr_out, e.addr);
          chk("sb_to_lsb", 32'(to_lsb), 32'(model_to_lsb(e.instr)));
          chk("sb_rob_id", 32'(rd_rob_id_out), 32'(rob_tail));
        end
      end
      if (instr_valid && instr_ready) sb_q.push_back('{instr: instr_in, addr: instr_addr_in});
    end
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{I_ADDI1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{I_STORE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{I_ADDI1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{I_LOAD,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{I_LOAD,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{I_ADDI2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{I_BEQ,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{I_LUI,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; rdy = 1'b1; instr_valid = 1'b0; instr_in = '0; instr_addr_in = '0;
    rob_full = 1'b0; rob_tail = '0; rs_full = 1'b0; lsb_full = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_issued", 32'(instr_issued), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_rob_id", 32'(rd_rob_id_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back ALU ops with rob_tail 0 then 1.
    cyc(1'b1, I_ADDI1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(0));
    chk("b2b_empty_issued", 32'(instr_issued), 32'd0);
    chk("b2b_empty_ready", 32'(instr_ready), 32'd1);
    cyc(1'b1, I_ADDI2, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(0));
    chk("b2b_issue1", 32'(instr_issued), 32'd1);
    chk("b2b_ready1", 32'(instr_ready), 32'd1);
    chk("b2b_robid0", 32'(rd_rob_id_out), 32'd0);
    chk("b2b_lsb0", 32'(to_lsb), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(1));
    chk("b2b_issue2", 32'(instr_issued), 32'd1);
    chk("b2b_robid1", 32'(rd_rob_id_out), 32'd1);
    chk("b2b_instr2", instr_out, I_ADDI2);
    idle();
    chk("b2b_drained", 32'(instr_issued), 32'd0);

    // Load held by a full LSB for three cycles.
    cyc(1'b1, I_LOAD, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, W'(2));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, W'(2));
      chk("ld_held_issued", 32'(instr_issued), 32'd0);
      chk("ld_held_ready", 32'(instr_ready), 32'd0);
      chk("ld_held_pc", instr_addr_out, 32'h200);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(2));
    chk("ld_stall3", stall_cycles, 32'd3);
    chk("ld_issued", 32'(instr_issued), 32'd1);
    chk("ld_to_lsb", 32'(to_lsb), 32'd1);
    chk("ld_pc", instr_addr_out, 32'h200);

    // Routing table: accept, apply full flags, drain if blocked.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(i));
      chk($sformatf("vec%0d_accept", i), 32'(instr_ready), 32'd1);
      cyc(1'b0, 32'h0, 32'h0, vecs[i].rob_full, vecs[i].rs_full, vecs[i].lsb_full,
          1'b0, 1'b1, W'(i + 1));
      chk($sformatf("vec%0d_issued", i), 32'(instr_issued), 32'(vecs[i].exp_issued));
      chk($sformatf("vec%0d_to_lsb", i), 32'(to_lsb), 32'(vecs[i].exp_to_lsb));
      if (!vecs[i].exp_issued) begin
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(i + 2));
        chk($sformatf("vec%0d_drain", i), 32'(instr_issued), 32'd1);
      end
    end
    idle();
    chk("table_stall", stall_cycles, 32'd7);

    // Flush with a full, blocked slot and a concurrent incoming word.
    cyc(1'b1, I_ADDI1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(3));
    cyc(1'b1, I_ADDI2, 32'h304, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, W'(3));
    chk("fl_issued", 32'(instr_issued), 32'd0);
    chk("fl_ready", 32'(instr_ready), 32'd0);
    sb_q.delete();
    idle();
    chk("fl_empty_issued", 32'(instr_issued), 32'd0);
    chk("fl_empty_ready", 32'(instr_ready), 32'd1);
    chk("fl_not_captured", 32'(instr_addr_out == 32'h304), 32'd0);
    chk("fl_stall", stall_cycles, 32'd7);

    // rdy low freezes an unblocked slot and the stall counter.
    cyc(1'b1, I_ADDI5, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(4));
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, I_ADDI2, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(4));
      chk("rdy0_issued", 32'(instr_issued), 32'd0);
      chk("rdy0_ready", 32'(instr_ready), 32'd0);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(5));
    chk("rdy1_issued", 32'(instr_issued), 32'd1);
    chk("rdy1_instr", instr_out, I_ADDI5);
    chk("rdy1_stall", stall_cycles, 32'd7);
    idle();

    // Asynchronous reset mid-run with a full, stalled slot.
    cyc(1'b1, I_ADDI1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(6));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, W'(6));
    chk("pre_rst_blocked", 32'(instr_issued), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(6));
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_issued", 32'(instr_issued), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_stall", stall_cycles, 32'd0);
    chk("mid_rst_instr", instr_out, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("post_rst_issued", 32'(instr_issued), 32'd0);
    idle();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
